// File: rtl/fifo_tx_drain.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_tx_drain
//  Brief    : Read-domain drain for the async FIFO. Pops one word per frame,
//             presents it to the UART transmitter with a valid strobe, waits
//             for the busy handshake, applies an inter-frame gap and counts
//             the words the transmitter accepted.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_tx_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  R_INC,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_DATA_VALID,
  output logic [CNT_WIDTH-1:0]  SENT_CNT
);

  // Gap counter only needs to hold GAP_CYCLES; keep at least one bit so the
  // GAP_CYCLES=0 build still has a legal (unused) register.
  localparam int                    c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [c_GAP_W-1:0]    c_GAP_LOAD = c_GAP_W'(GAP_CYCLES);
  localparam logic [c_GAP_W-1:0]    c_GAP_ONE  = c_GAP_W'(1);
  localparam logic [CNT_WIDTH-1:0]  c_CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_BUSY    = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_pop;
  logic                    w_accept;
  logic [c_GAP_W-1:0]      r_gap_cnt;
  logic [c_GAP_W-1:0]      w_gap_nxt;
  logic [DATA_WIDTH-1:0]   r_tx_p_data;
  logic                    r_tx_data_valid;
  logic [CNT_WIDTH-1:0]    r_sent_cnt;

  // State register; reset lands in IDLE without waiting for a clock edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, pop/accept strobes and gap counter next value.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_accept    = 1'b0;
    w_gap_nxt   = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        // EN and EMPTY only matter here; a busy transmitter blocks the pop.
        if (EN && !EMPTY && !TX_BUSY) begin
          w_pop       = 1'b1;
          w_state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        // No timeout: the word stays presented until the transmitter takes it.
        if (TX_BUSY) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!TX_BUSY) begin
          if (GAP_CYCLES == 0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_GAP;
            w_gap_nxt   = c_GAP_LOAD;
          end
        end
      end
      S_GAP: begin
        // Leave on the edge where the counter reaches zero.
        w_gap_nxt = r_gap_cnt - c_GAP_ONE;
        if (r_gap_cnt <= c_GAP_ONE) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Capture data on the pop edge, drive valid, count accepted words.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_tx_p_data     <= '0;
      r_tx_data_valid <= 1'b0;
      r_sent_cnt      <= '0;
      r_gap_cnt       <= '0;
    end else begin
      if (w_pop) begin
        r_tx_p_data     <= RD_DATA;
        r_tx_data_valid <= 1'b1;
      end
      if (w_accept) begin
        r_tx_data_valid <= 1'b0;
        r_sent_cnt      <= r_sent_cnt + c_CNT_ONE;
      end
      r_gap_cnt <= w_gap_nxt;
    end
  end

  // The pop request is combinational so the FIFO pointer moves on the same
  // edge that captures RD_DATA; it is forced low while reset is asserted.
  assign R_INC         = w_pop & RST;
  assign TX_P_DATA     = r_tx_p_data;
  assign TX_DATA_VALID = r_tx_data_valid;
  assign SENT_CNT      = r_sent_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_tx_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_tx_drain
//  Brief    : Self-checking bench for fifo_tx_drain. A table of per-cycle
//             vectors drives the default build; hand-written sequences cover
//             reset mid-frame and counter wrap on a 2-bit, zero-gap build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_tx_drain;

  logic       CLK;
  logic       RST;
  logic       EN;
  logic       EMPTY;
  logic [7:0] RD_DATA;
  logic       R_INC;
  logic       TX_BUSY;
  logic [7:0] TX_P_DATA;
  logic       TX_DATA_VALID;
  logic [7:0] SENT_CNT;

  logic       en2;
  logic       emp2;
  logic [7:0] rd2;
  logic       rinc2;
  logic       bz2;
  logic [7:0] d2;
  logic       v2;
  logic [1:0] cnt2;

  int total;
  int bad;

  fifo_tx_drain #(.DATA_WIDTH(8), .GAP_CYCLES(2), .CNT_WIDTH(8)) u_dut (
    .CLK           (CLK),
    .RST           (RST),
    .EN            (EN),
    .EMPTY         (EMPTY),
    .RD_DATA       (RD_DATA),
    .R_INC         (R_INC),
    .TX_BUSY       (TX_BUSY),
    .TX_P_DATA     (TX_P_DATA),
    .TX_DATA_VALID (TX_DATA_VALID),
    .SENT_CNT      (SENT_CNT)
  );

  fifo_tx_drain #(.DATA_WIDTH(8), .GAP_CYCLES(0), .CNT_WIDTH(2)) u_dut_c2 (
    .CLK           (CLK),
    .RST           (RST),
    .EN            (en2),
    .EMPTY         (emp2),
    .RD_DATA       (rd2),
    .R_INC         (rinc2),
    .TX_BUSY       (bz2),
    .TX_P_DATA     (d2),
    .TX_DATA_VALID (v2),
    .SENT_CNT      (cnt2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int         reps;
    logic       en;
    logic       empty;
    logic [7:0] rd;
    logic       busy;
    logic       exp_rinc;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int reps, input logic en, input logic empty,
                         input logic [7:0] rd, input logic busy,
                         input logic exp_rinc, input logic exp_valid,
                         input logic [7:0] exp_data, input logic [7:0] exp_cnt);
    vec_t v;
    v.reps      = reps;
    v.en        = en;
    v.empty     = empty;
    v.rd        = rd;
    v.busy      = busy;
    v.exp_rinc  = exp_rinc;
    v.exp_valid = exp_valid;
    v.exp_data  = exp_data;
    v.exp_cnt   = exp_cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] words[5];
    logic [1:0] exp_wrap[5];

    total = 0;
    bad   = 0;

    // Per-cycle vectors for the GAP_CYCLES=2 build, starting right after reset.
    //       reps en emp rd     bz  rinc vld data   cnt
    add_vec(1,  1, 1, 8'h00, 0,  0,  0,  8'h00, 8'd0);  // empty: no pop
    add_vec(1,  1, 0, 8'hA5, 0,  1,  0,  8'h00, 8'd0);  // pop A5
    add_vec(20, 1, 1, 8'h00, 0,  0,  1,  8'hA5, 8'd0);  // held, no timeout
    add_vec(1,  1, 1, 8'h00, 1,  0,  1,  8'hA5, 8'd0);  // accepted
    add_vec(1,  1, 1, 8'h00, 1,  0,  0,  8'hA5, 8'd1);
    add_vec(1,  1, 1, 8'h00, 0,  0,  0,  8'hA5, 8'd1);  // busy falls
    add_vec(2,  1, 0, 8'h11, 0,  0,  0,  8'hA5, 8'd1);  // gap: no pop
    add_vec(1,  1, 0, 8'h11, 0,  1,  0,  8'hA5, 8'd1);  // pop 11
    add_vec(1,  1, 0, 8'h22, 0,  0,  1,  8'h11, 8'd1);
    add_vec(1,  1, 0, 8'h22, 1,  0,  1,  8'h11, 8'd1);
    add_vec(9,  1, 0, 8'h22, 1,  0,  0,  8'h11, 8'd2);
    add_vec(3,  1, 0, 8'h22, 0,  0,  0,  8'h11, 8'd2);  // fall + 2 gap
    add_vec(1,  1, 0, 8'h22, 0,  1,  0,  8'h11, 8'd2);  // pop 22
    add_vec(1,  1, 0, 8'h33, 1,  0,  1,  8'h22, 8'd2);
    add_vec(9,  1, 0, 8'h33, 1,  0,  0,  8'h22, 8'd3);
    add_vec(3,  1, 0, 8'h33, 0,  0,  0,  8'h22, 8'd3);
    add_vec(1,  1, 0, 8'h33, 0,  1,  0,  8'h22, 8'd3);  // pop 33
    add_vec(1,  1, 1, 8'h00, 1,  0,  1,  8'h33, 8'd3);  // empty rises in PRESENT
    add_vec(9,  1, 1, 8'h00, 1,  0,  0,  8'h33, 8'd4);
    add_vec(3,  1, 1, 8'h00, 0,  0,  0,  8'h33, 8'd4);
    add_vec(5,  1, 1, 8'h00, 0,  0,  0,  8'h33, 8'd4);  // idle, empty
    add_vec(3,  1, 0, 8'h44, 1,  0,  0,  8'h33, 8'd4);  // tx busy externally
    add_vec(50, 0, 0, 8'h44, 0,  0,  0,  8'h33, 8'd4);  // EN=0 blocks pop
    add_vec(1,  1, 0, 8'h44, 0,  1,  0,  8'h33, 8'd4);  // pop 44
    add_vec(1,  0, 0, 8'h55, 0,  0,  1,  8'h44, 8'd4);  // EN drop keeps word
    add_vec(1,  0, 0, 8'h55, 1,  0,  1,  8'h44, 8'd4);
    add_vec(4,  0, 0, 8'h55, 1,  0,  0,  8'h44, 8'd5);
    add_vec(3,  0, 0, 8'h55, 0,  0,  0,  8'h44, 8'd5);
    add_vec(10, 0, 0, 8'h55, 0,  0,  0,  8'h44, 8'd5);  // no further pop
    add_vec(1,  1, 0, 8'h5A, 0,  1,  0,  8'h44, 8'd5);  // pop 5A
    add_vec(1,  1, 1, 8'h00, 0,  0,  1,  8'h5A, 8'd5);

    words    = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45};
    exp_wrap = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset with pop-ready inputs: R_INC must still stay low.
    RST = 1'b0; EN = 1'b1; EMPTY = 1'b0; RD_DATA = 8'hEE; TX_BUSY = 1'b0;
    en2 = 1'b0; emp2 = 1'b1; rd2 = 8'h00; bz2 = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset rinc",  32'(R_INC),         32'd0);
    check("reset valid", 32'(TX_DATA_VALID), 32'd0);
    check("reset data",  32'(TX_P_DATA),     32'h00);
    check("reset cnt",   32'(SENT_CNT),      32'd0);
    check("reset cnt2",  32'(cnt2),          32'd0);
    EMPTY = 1'b1;
    RST   = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        @(posedge CLK);
        #1;
        EN      = vecs[i].en;
        EMPTY   = vecs[i].empty;
        RD_DATA = vecs[i].rd;
        TX_BUSY = vecs[i].busy;
        @(negedge CLK);
        check($sformatf("v%0d.%0d rinc", i, r),  32'(R_INC),         32'(vecs[i].exp_rinc));
        check($sformatf("v%0d.%0d valid", i, r), 32'(TX_DATA_VALID), 32'(vecs[i].exp_valid));
        check($sformatf("v%0d.%0d data", i, r),  32'(TX_P_DATA),     32'(vecs[i].exp_data));
        check($sformatf("v%0d.%0d cnt", i, r),   32'(SENT_CNT),      32'(vecs[i].exp_cnt));
      end
    end

    // Reset mid-frame: outputs clear before the next clock edge.
    @(posedge CLK);
    #1;
    check("pre-rst valid", 32'(TX_DATA_VALID), 32'd1);
    check("pre-rst data",  32'(TX_P_DATA),     32'h5A);
    #1;
    EN = 1'b1; EMPTY = 1'b0; TX_BUSY = 1'b0; RD_DATA = 8'h3C;
    RST = 1'b0;
    #1;
    check("async rst valid", 32'(TX_DATA_VALID), 32'd0);
    check("async rst data",  32'(TX_P_DATA),     32'h00);
    check("async rst cnt",   32'(SENT_CNT),      32'd0);
    check("async rst rinc",  32'(R_INC),         32'd0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("post-rst idle rinc", 32'(R_INC), 32'd1);
    @(posedge CLK);
    #1;
    EMPTY = 1'b1;
    check("post-rst valid", 32'(TX_DATA_VALID), 32'd1);
    check("post-rst data",  32'(TX_P_DATA),     32'h3C);
    check("post-rst rinc",  32'(R_INC),         32'd0);

    // 2-bit counter, zero gap: count wraps and IDLE follows BUSY directly.
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK);
      #1;
      en2 = 1'b1; emp2 = 1'b0; rd2 = words[k];
      @(negedge CLK);
      check($sformatf("wrap%0d rinc", k), 32'(rinc2), 32'd1);
      @(posedge CLK);
      #1;
      emp2 = 1'b1; bz2 = 1'b1;
      @(negedge CLK);
      check($sformatf("wrap%0d valid", k), 32'(v2), 32'd1);
      check($sformatf("wrap%0d data", k),  32'(d2), 32'(words[k]));
      @(posedge CLK);
      #1;
      @(negedge CLK);
      check($sformatf("wrap%0d valid off", k), 32'(v2),   32'd0);
      check($sformatf("wrap%0d cnt", k),       32'(cnt2), 32'(exp_wrap[k]));
      @(posedge CLK);
      #1;
      bz2 = 1'b0;
      @(negedge CLK);
      check($sformatf("wrap%0d busy rinc", k), 32'(rinc2), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
